product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Downstream consumer of the MBE multiplier wrapper's output handshake. Accepts a stream of signed products over valid/ready.
- Sums each block of BLOCK_LEN consecutive products into a wide accumulator, then emits the block sum and an overflow flag over a second valid/ready interface.
- Forms the MAC/dot-product stage behind the MBE multiplier in the datapath.

Parameters:
- PROD_W, 64: product width in bits, signed two's complement (matches multiplier result width).
- ACC_W, 72: accumulator and output width in bits, signed; must be >= PROD_W.
- BLOCK_LEN, 4: products summed per output; must be >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream product valid.
- in_ready  out  1  block can accept a product.
- in_data  in  PROD_W  signed product.
- out_valid  out  1  block sum valid.
- out_ready  in  1  downstream accepts the sum.
- out_data  out  ACC_W  signed block sum.
- out_ovf  out  1  overflow occurred within this block; qualified by out_valid.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: in_ready=0, out_valid=0, out_data=0, out_ovf=0, acc=0, count=0, state=INIT.
- Reset mid-operation: the partial block is discarded. A pending out_valid drops on the next edge with no transfer.
- Transfer rules: an input transfer occurs when in_valid&&in_ready at an edge. An output transfer occurs when out_valid&&out_ready at an edge.
- in_data is sign-extended to ACC_W before it is added.
- FSM state INIT: on the next edge, in_ready<=1 and state goes to ACC.
- FSM state ACC, accepting a product with count<BLOCK_LEN-1: acc<=acc+ext(in_data), count++.
- FSM state ACC, accepting a product with count==BLOCK_LEN-1:
  - out_data<=acc+ext(in_data), out_valid<=1, in_ready<=0, state goes to SEND.
  - out_ovf<=the sticky overflow for the block, including this add.
- FSM state SEND:
  - out_data and out_ovf are held stable while out_valid=1.
  - On output transfer: out_valid<=0, acc<=0, count<=0, ovf_sticky<=0, in_ready<=1, state goes to ACC.
- Latency: out_valid rises on the edge that accepts the last product of a block.
- Throughput: at least one cycle per block in SEND. Back-to-back blocks therefore have a one-cycle in_ready gap.
- in_ready is registered. It is never combinationally dependent on out_ready.
- No input is accepted in SEND. Upstream must hold in_valid/in_data.
- Overflow detection: signed overflow when both addends have the same sign and the sum's sign differs. When it occurs, set ovf_sticky for the block.
- BLOCK_LEN=1: every accepted product goes directly to SEND. out_data=ext(in_data) and out_ovf=0.
- Holding in_valid with in_ready=0 causes no accumulation.

Optional Feature:
- Macro: PRODUCT_ACC_SATURATE_EN.
- Defined: on overflow the sum clamps to the signed ACC_W maximum (positive overflow) or minimum (negative overflow). Later adds start from the clamped value. out_ovf is still set.
- Undefined: the sum wraps modulo 2^ACC_W and out_ovf is set.
- Handshake and timing are identical in both builds.

Decomposition:
- Package product_acc_pkg:
  - state enum typedef: INIT, ACC, SEND (logic [1:0]).
  - ACC_MAX and ACC_MIN constant functions of ACC_W.
  - count width as $clog2(BLOCK_LEN+1).
- Sub-module acc_add_sat: combinational; inputs acc and ext product; outputs sum and ovf. The saturation macro is confined to this sub-module.
- The top level holds the FSM, count and registers.

Test Plan:
- Reset then stream 3,5,-2,10 with out_ready=1 -> in_ready=1 one cycle after reset deasserts; out_data=16, out_ovf=0; out_valid rises on the edge accepting 10 and is high for one cycle.
- Backpressure: hold out_ready=0 for 5 cycles after a block of products 1,1,1,1 -> out_data=4 stable; in_ready=0 throughout; in_valid held high with in_data=7 is not accumulated; next block begins only after the transfer.
- Overflow, ACC_W=PROD_W=64, products 2^62, 2^62, 0, 0:
  - Without the macro: out_data=-2^63, out_ovf=1.
  - With PRODUCT_ACC_SATURATE_EN: out_data=2^63-1, out_ovf=1.
  - Next block 1,1,1,1 gives out_ovf=0.
- Reset mid-block: accept 100,200, then pulse rst, then send 1,2,3,4 -> out_data=10; no out_valid during or just after the reset.
- BLOCK_LEN=1, stream -7,9 with out_ready=1 -> two outputs, -7 then 9; in_ready shows one low cycle per output; out_ovf=0.
- Random in_valid/out_ready throttling over 1000 products -> block sums match a scoreboard; no product lost or duplicated.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator slice.
// Build option: define PRODUCT_ACC_SATURATE_EN to make block sums clamp on
// overflow instead of wrapping (see acc_add_sat).
package product_acc_pkg;

    // Widest accumulator the min/max helpers can describe.
    localparam int MAX_W = 256;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        ACC  = 2'd1,
        SEND = 2'd2
    } acc_state_t;

    // Largest signed value representable in acc_w bits, zero-extended to MAX_W.
    function automatic logic [MAX_W-1:0] acc_max(input int acc_w);
        return (MAX_W'(1) << (acc_w - 1)) - MAX_W'(1);
    endfunction

    // Most negative signed value of acc_w bits (only the sign bit set).
    function automatic logic [MAX_W-1:0] acc_min(input int acc_w);
        return MAX_W'(1) << (acc_w - 1);
    endfunction

    // Counter width able to hold 0..block_len.
    function automatic int count_width(input int block_len);
        return $clog2(block_len + 1);
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product input stream and block-sum output stream, bundled for the
// accumulator. The slave side is the accumulator, master is its environment.
interface product_accumulator_if #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 72
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/product_accumulator_acc_add_sat.sv
// Signed accumulate step: acc + addend with overflow detection.
// Build option: PRODUCT_ACC_SATURATE_EN clamps the sum to the signed ACC_W
// range on overflow; without it the sum wraps. ovf is reported either way.
module acc_add_sat
    import product_acc_pkg::*;
#(
    parameter int ACC_W = 72
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] addend,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

`ifdef PRODUCT_ACC_SATURATE_EN
    localparam logic [MAX_W-1:0] MAX_FULL = acc_max(ACC_W);
    localparam logic [MAX_W-1:0] MIN_FULL = acc_min(ACC_W);
    localparam logic [ACC_W-1:0] SAT_MAX  = MAX_FULL[ACC_W-1:0];
    localparam logic [ACC_W-1:0] SAT_MIN  = MIN_FULL[ACC_W-1:0];
`endif

    logic [ACC_W-1:0] raw;

    // Overflow is a same-sign pair of addends yielding a result of the other sign.
    always_comb begin
        raw = acc + addend;
        ovf = (acc[ACC_W-1] == addend[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
`ifdef PRODUCT_ACC_SATURATE_EN
        if (ovf) begin
            sum = acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            sum = raw;
        end
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/product_accumulator.sv
// Block accumulator behind the MBE multiplier: sums BLOCK_LEN signed products
// and hands out each block sum with a sticky overflow flag.
// Build option: PRODUCT_ACC_SATURATE_EN (clamping sums, handled in acc_add_sat).
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int PROD_W    = 64,
    parameter int ACC_W     = 72,
    parameter int BLOCK_LEN = 4
) (
    input logic                  clk,
    input logic                  rst,
    product_accumulator_if.slave bus
);

    localparam int             CNT_W = count_width(BLOCK_LEN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BLOCK_LEN - 1);

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] ext_data;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] count;
    logic             ovf_sticky;
    logic             add_ovf;

    // Products arrive as signed PROD_W values; widen with sign before adding.
    assign ext_data = ACC_W'($signed(bus.in_data));

    acc_add_sat #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc    (acc),
        .addend (ext_data),
        .sum    (sum),
        .ovf    (add_ovf)
    );

    // Handshake FSM: accumulate a block, then hold the sum until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= INIT;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ovf   <= 1'b0;
            acc           <= '0;
            count         <= '0;
            ovf_sticky    <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    bus.in_ready <= 1'b1;
                    state        <= ACC;
                end
                ACC: begin
                    if (bus.in_valid && bus.in_ready) begin
                        if (count == LAST) begin
                            bus.out_data  <= sum;
                            bus.out_ovf   <= ovf_sticky | add_ovf;
                            bus.out_valid <= 1'b1;
                            bus.in_ready  <= 1'b0;
                            state         <= SEND;
                        end else begin
                            acc        <= sum;
                            count      <= count + 1'b1;
                            ovf_sticky <= ovf_sticky | add_ovf;
                        end
                    end
                end
                SEND: begin
                    if (bus.out_valid && bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        acc           <= '0;
                        count         <= '0;
                        ovf_sticky    <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= ACC;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator. Three instances: the default
// configuration, a 64-bit accumulator for overflow cases, and BLOCK_LEN=1.
// Build option: PRODUCT_ACC_SATURATE_EN selects clamped overflow expectations.
module tb_product_accumulator;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    product_accumulator_if #(.PROD_W(64), .ACC_W(72)) m_if ();
    product_accumulator_if #(.PROD_W(64), .ACC_W(64)) o_if ();
    product_accumulator_if #(.PROD_W(64), .ACC_W(72)) b_if ();

    product_accumulator #(.PROD_W(64), .ACC_W(72), .BLOCK_LEN(4)) dut_main (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    product_accumulator #(.PROD_W(64), .ACC_W(64), .BLOCK_LEN(4)) dut_ovf (
        .clk (clk),
        .rst (rst),
        .bus (o_if)
    );

    product_accumulator #(.PROD_W(64), .ACC_W(72), .BLOCK_LEN(1)) dut_b1 (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop so a stuck handshake can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive the input stream of instance 0 (main), 1 (ovf) or 2 (block length 1).
    task automatic drive(input int which, input logic v, input logic [63:0] d);
        case (which)
            0: begin m_if.in_valid = v; m_if.in_data = d; end
            1: begin o_if.in_valid = v; o_if.in_data = d; end
            default: begin b_if.in_valid = v; b_if.in_data = d; end
        endcase
    endtask

    function automatic logic rdy(input int which);
        case (which)
            0: return m_if.in_ready;
            1: return o_if.in_ready;
            default: return b_if.in_ready;
        endcase
    endfunction

    // Present one product and return on the rising edge that accepts it.
    task automatic send(input int which, input logic [63:0] d);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        drive(which, 1'b1, d);
        for (int i = 0; i < 50; i++) begin
            if (rdy(which)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
        end else begin
            failures++;
            $display("[TB] FAIL send_timeout dut=%0d: in_ready never rose within 50 cycles, required 1", which);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        drive(2, 1'b0, '0);
        m_if.out_ready = 1'b0;
        o_if.out_ready = 1'b0;
        b_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (m_if.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b, required 0", m_if.in_ready);
        end
        checks++;
        if (m_if.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid: got %b, required 0", m_if.out_valid);
        end
        checks++;
        if (m_if.out_data !== 72'd0) begin
            failures++;
            $display("[TB] FAIL reset_out_data: got %h, required 0", m_if.out_data);
        end
        checks++;
        if (m_if.out_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_ovf: got %b, required 0", m_if.out_ovf);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_if.in_ready, o_if.in_ready, b_if.in_ready} !== 3'b111) begin
            failures++;
            $display("[TB] FAIL ready_after_reset: got %b, required 111",
                     {m_if.in_ready, o_if.in_ready, b_if.in_ready});
        end
    endtask

    task automatic test_basic_stream;
        m_if.out_ready = 1'b1;
        send(0, 64'd3);
        send(0, 64'd5);
        send(0, 64'(-2));
        send(0, 64'd10);
        @(negedge clk);
        drive(0, 1'b0, '0);
        checks++;
        if (m_if.out_valid !== 1'b1 || m_if.out_data !== 72'd16 || m_if.out_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_sum: got valid=%b data=%0d ovf=%b, required valid=1 data=16 ovf=0",
                     m_if.out_valid, $signed(m_if.out_data), m_if.out_ovf);
        end
        checks++;
        if (m_if.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_ready_in_send: got %b, required 0", m_if.in_ready);
        end
        @(negedge clk);
        checks++;
        if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_one_cycle_valid: got valid=%b ready=%b, required valid=0 ready=1",
                     m_if.out_valid, m_if.in_ready);
        end
    endtask

    task automatic test_backpressure;
        m_if.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 64'd1);
        @(negedge clk);
        drive(0, 1'b1, 64'd7);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (m_if.out_valid !== 1'b1 || m_if.out_data !== 72'd4 || m_if.in_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stall_hold cycle=%0d: got valid=%b data=%0d ready=%b, required valid=1 data=4 ready=0",
                         i, m_if.out_valid, $signed(m_if.out_data), m_if.in_ready);
            end
            @(negedge clk);
        end
        m_if.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_release: got valid=%b ready=%b, required valid=0 ready=1",
                     m_if.out_valid, m_if.in_ready);
        end
        @(posedge clk);
        send(0, 64'd2);
        send(0, 64'd3);
        send(0, 64'd4);
        @(negedge clk);
        drive(0, 1'b0, '0);
        checks++;
        if (m_if.out_valid !== 1'b1 || m_if.out_data !== 72'd16) begin
            failures++;
            $display("[TB] FAIL stall_next_block: got valid=%b data=%0d, required valid=1 data=16",
                     m_if.out_valid, $signed(m_if.out_data));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        m_if.out_ready = 1'b1;
        send(0, 64'd100);
        send(0, 64'd200);
        @(negedge clk);
        drive(0, 1'b0, '0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_during: got valid=%b ready=%b, required valid=0 ready=0",
                     m_if.out_valid, m_if.in_ready);
        end
        @(negedge clk);
        checks++;
        if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_after: got valid=%b ready=%b, required valid=0 ready=1",
                     m_if.out_valid, m_if.in_ready);
        end
        m_if.out_ready = 1'b0;
        send(0, 64'd1);
        send(0, 64'd2);
        send(0, 64'd3);
        send(0, 64'd4);
        @(negedge clk);
        drive(0, 1'b0, '0);
        checks++;
        if (m_if.out_valid !== 1'b1 || m_if.out_data !== 72'd10) begin
            failures++;
            $display("[TB] FAIL midreset_sum: got valid=%b data=%0d, required valid=1 data=10",
                     m_if.out_valid, $signed(m_if.out_data));
        end
        // A pending sum is dropped by reset without a transfer.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_if.out_ready = 1'b1;
        checks++;
        if (m_if.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_drops_pending: got valid=%b, required 0", m_if.out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        logic [63:0] exp_pos;
        logic [63:0] exp_neg;
`ifdef PRODUCT_ACC_SATURATE_EN
        exp_pos = 64'h7FFF_FFFF_FFFF_FFFF;
        exp_neg = 64'h8000_0000_0000_0000;
`else
        exp_pos = 64'h8000_0000_0000_0000;
        exp_neg = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
        o_if.out_ready = 1'b1;
        send(1, 64'h4000_0000_0000_0000);
        send(1, 64'h4000_0000_0000_0000);
        send(1, 64'd0);
        send(1, 64'd0);
        @(negedge clk);
        drive(1, 1'b0, '0);
        checks++;
        if (o_if.out_valid !== 1'b1 || o_if.out_data !== exp_pos || o_if.out_ovf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_positive: got valid=%b data=%h ovf=%b, required valid=1 data=%h ovf=1",
                     o_if.out_valid, o_if.out_data, o_if.out_ovf, exp_pos);
        end
        for (int i = 0; i < 4; i++) send(1, 64'd1);
        @(negedge clk);
        drive(1, 1'b0, '0);
        checks++;
        if (o_if.out_valid !== 1'b1 || o_if.out_data !== 64'd4 || o_if.out_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_cleared: got valid=%b data=%h ovf=%b, required valid=1 data=4 ovf=0",
                     o_if.out_valid, o_if.out_data, o_if.out_ovf);
        end
        send(1, 64'h8000_0000_0000_0000);
        send(1, 64'(-1));
        send(1, 64'd0);
        send(1, 64'd0);
        @(negedge clk);
        drive(1, 1'b0, '0);
        checks++;
        if (o_if.out_valid !== 1'b1 || o_if.out_data !== exp_neg || o_if.out_ovf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_negative: got valid=%b data=%h ovf=%b, required valid=1 data=%h ovf=1",
                     o_if.out_valid, o_if.out_data, o_if.out_ovf, exp_neg);
        end
        @(negedge clk);
    endtask

    task automatic test_block_len1;
        logic [71:0] exp_a;
        exp_a = 72'(-7);
        b_if.out_ready = 1'b1;
        send(2, 64'(-7));
        @(negedge clk);
        drive(2, 1'b1, 64'd9);
        checks++;
        if (b_if.out_valid !== 1'b1 || b_if.out_data !== exp_a || b_if.out_ovf !== 1'b0 || b_if.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL len1_first: got valid=%b data=%0d ovf=%b ready=%b, required valid=1 data=-7 ovf=0 ready=0",
                     b_if.out_valid, $signed(b_if.out_data), b_if.out_ovf, b_if.in_ready);
        end
        @(negedge clk);
        checks++;
        if (b_if.out_valid !== 1'b0 || b_if.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL len1_gap: got valid=%b ready=%b, required valid=0 ready=1",
                     b_if.out_valid, b_if.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        drive(2, 1'b0, '0);
        checks++;
        if (b_if.out_valid !== 1'b1 || b_if.out_data !== 72'd9 || b_if.out_ovf !== 1'b0 || b_if.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL len1_second: got valid=%b data=%0d ovf=%b ready=%b, required valid=1 data=9 ovf=0 ready=0",
                     b_if.out_valid, $signed(b_if.out_data), b_if.out_ovf, b_if.in_ready);
        end
        @(negedge clk);
    endtask

    // Randomly throttled stream of 1000 products; each block sum is the exact
    // integer sum of its four products, flagged if any running sum leaves
    // the 72-bit signed range.
    task automatic test_random;
        logic signed [79:0] exact;
        logic [71:0]        exp_q[$];
        logic               exp_ovf_q[$];
        logic [71:0]        exp_d;
        logic               exp_o;
        logic [71:0]        held_data;
        logic               held;
        logic               hold_in;
        logic               blk_ovf;
        logic               in_fire;
        logic               out_fire;
        int                 nprod;
        int                 nout;
        int                 cnt;
        exact     = '0;
        blk_ovf   = 1'b0;
        held      = 1'b0;
        held_data = '0;
        hold_in   = 1'b0;
        nprod     = 0;
        nout      = 0;
        cnt       = 0;
        for (int cyc = 0; cyc < 20000 && nout < 250; cyc++) begin
            @(negedge clk);
            if (!hold_in) begin
                if (nprod < 1000 && $urandom_range(0, 99) < 70) begin
                    drive(0, 1'b1, {$urandom, $urandom});
                end else begin
                    drive(0, 1'b0, '0);
                end
            end
            m_if.out_ready = ($urandom_range(0, 99) < 60);
            if (held) begin
                checks++;
                if (m_if.out_valid !== 1'b1 || m_if.out_data !== held_data) begin
                    failures++;
                    $display("[TB] FAIL rand_hold: got valid=%b data=%h, required valid=1 data=%h",
                             m_if.out_valid, m_if.out_data, held_data);
                end
            end
            in_fire  = m_if.in_valid && m_if.in_ready;
            out_fire = m_if.out_valid && m_if.out_ready;
            if (out_fire) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL rand_extra_output: got data=%h, required no output", m_if.out_data);
                end else begin
                    exp_d = exp_q.pop_front();
                    exp_o = exp_ovf_q.pop_front();
                    if (m_if.out_data !== exp_d || m_if.out_ovf !== exp_o) begin
                        failures++;
                        $display("[TB] FAIL rand_block %0d: got data=%h ovf=%b, required data=%h ovf=%b",
                                 nout, m_if.out_data, m_if.out_ovf, exp_d, exp_o);
                    end
                end
                nout++;
            end
            held      = m_if.out_valid && !out_fire;
            held_data = m_if.out_data;
            if (in_fire) begin
                exact = exact + 80'($signed(m_if.in_data));
                if (exact > 80'sd2361183241434822606847 || exact < -80'sd2361183241434822606848) begin
                    blk_ovf = 1'b1;
                end
                nprod++;
                cnt++;
                if (cnt == 4) begin
                    exp_q.push_back(exact[71:0]);
                    exp_ovf_q.push_back(blk_ovf);
                    exact   = '0;
                    blk_ovf = 1'b0;
                    cnt     = 0;
                end
            end
            hold_in = m_if.in_valid && !in_fire;
        end
        @(negedge clk);
        drive(0, 1'b0, '0);
        checks++;
        if (nprod != 1000 || nout != 250 || exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL rand_totals: got products=%0d outputs=%0d pending=%0d, required 1000/250/0",
                     nprod, nout, exp_q.size());
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        drive(2, 1'b0, '0);
        m_if.out_ready = 1'b0;
        o_if.out_ready = 1'b0;
        b_if.out_ready = 1'b0;
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_reset_mid();
        test_overflow();
        test_block_len1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
